// File: rtl/dlx_pipe_if.sv
// dlx_pipe_if: DLX instruction-fetch stage owning the PC, the fetch request and the IF/ID register.
// Ports: clk/rst (sync, active-low); stall, dc_wait freeze the stage;
//        id_cond/id_npc redirect, id_halt/id_illegal_instr halt (from decode);
//        im_adr/im_req/im_data/im_ready instruction-memory handshake;
//        if_id_ir/if_id_npc IF/ID register; if_halted, if_exc_code, if_fetch_cnt status.
module dlx_pipe_if #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        dc_wait,
    input  logic        id_cond,
    input  logic [31:0] id_npc,
    input  logic        id_halt,
    input  logic        id_illegal_instr,
    output logic [31:0] im_adr,
    output logic        im_req,
    input  logic [31:0] im_data,
    input  logic        im_ready,
    output logic [31:0] if_id_ir,
    output logic [31:0] if_id_npc,
    output logic        if_halted,
    output logic [1:0]  if_exc_code,
    output logic [31:0] if_fetch_cnt
);
    typedef enum logic [1:0] {RUN, WAIT, HALT} state_t;
    state_t      state, state_n;
    logic [31:0] pc, pc_n, ir_n, npc_n, cnt, cnt_n;
    logic [1:0]  exc_n;
    logic        hold;
    assign hold         = stall | dc_wait;
    assign im_adr       = pc;
    assign im_req       = (state != HALT) && !hold;
    assign if_halted    = state == HALT;
    assign if_fetch_cnt = cnt;
    always_comb begin
        state_n = state;
        pc_n    = pc;
        ir_n    = if_id_ir;
        npc_n   = if_id_npc;
        cnt_n   = cnt;
        exc_n   = if_exc_code;
        if (state == HALT) begin
            ir_n = NOP_WORD;
        end else if (hold) begin
            state_n = state;
        end else if (id_halt || id_illegal_instr) begin
            state_n = HALT;
            ir_n    = NOP_WORD;
            exc_n   = id_illegal_instr ? 2'b01 : 2'b00;
        end else if (id_cond && id_npc[1:0] != 2'b00) begin
            state_n = HALT;
            ir_n    = NOP_WORD;
            exc_n   = 2'b10;
        end else if (id_cond) begin
            // The word fetched this cycle is on the wrong path, so it is squashed.
            state_n = RUN;
            pc_n    = id_npc;
            ir_n    = NOP_WORD;
        end else if (im_ready) begin
            state_n = RUN;
            pc_n    = pc + 32'd4;
            npc_n   = pc + 32'd4;
            ir_n    = im_data;
            cnt_n   = cnt + 32'd1;
        end else begin
            state_n = WAIT;
            ir_n    = NOP_WORD;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= RUN;
            pc          <= RESET_PC;
            if_id_ir    <= NOP_WORD;
            if_id_npc   <= RESET_PC;
            cnt         <= 32'd0;
            if_exc_code <= 2'b00;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            if_id_ir    <= ir_n;
            if_id_npc   <= npc_n;
            cnt         <= cnt_n;
            if_exc_code <= exc_n;
        end
    end
endmodule

// File: tb/tb_dlx_pipe_if.sv
// tb_dlx_pipe_if: directed self-checking bench for dlx_pipe_if.
module tb_dlx_pipe_if;
    localparam logic [31:0] NOP = 32'hA5A5_0000;
    logic        clk = 1'b0;
    logic        rst, stall, dc_wait, id_cond, id_halt, id_illegal_instr, im_req, im_ready, if_halted;
    logic [31:0] id_npc, im_adr, im_data, if_id_ir, if_id_npc, if_fetch_cnt;
    logic [1:0]  if_exc_code;
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;
    dlx_pipe_if #(.RESET_PC(32'h0), .NOP_WORD(NOP)) dut (
        .clk(clk), .rst(rst), .stall(stall), .dc_wait(dc_wait), .id_cond(id_cond),
        .id_npc(id_npc), .id_halt(id_halt), .id_illegal_instr(id_illegal_instr),
        .im_adr(im_adr), .im_req(im_req), .im_data(im_data), .im_ready(im_ready),
        .if_id_ir(if_id_ir), .if_id_npc(if_id_npc), .if_halted(if_halted),
        .if_exc_code(if_exc_code), .if_fetch_cnt(if_fetch_cnt)
    );
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic step;
        @(posedge clk);
        #1;
    endtask
    task automatic st(input string tag, input logic [31:0] adr, input logic [31:0] ir,
                      input logic [31:0] npc, input logic [31:0] cnt);
        chk({tag, "_adr"}, im_adr, adr);
        chk({tag, "_ir"}, if_id_ir, ir);
        chk({tag, "_npc"}, if_id_npc, npc);
        chk({tag, "_cnt"}, if_fetch_cnt, cnt);
    endtask
    initial begin
        rst = 0; stall = 0; dc_wait = 0; id_cond = 0; id_npc = 0;
        id_halt = 0; id_illegal_instr = 0; im_data = 0; im_ready = 0;
        step;
        st("reset", 32'h0, NOP, 32'h0, 32'h0);
        chk("reset_req", {31'b0, im_req}, 32'd1);
        chk("reset_halted", {31'b0, if_halted}, 32'd0);
        chk("reset_exc", {30'b0, if_exc_code}, 32'd0);
        // sequential fetch
        rst = 1; im_ready = 1; im_data = 32'h11;
        step; st("f1", 32'h4, 32'h11, 32'h4, 32'd1);
        im_data = 32'h22;
        step; st("f2", 32'h8, 32'h22, 32'h8, 32'd2);
        im_data = 32'h33;
        step; st("f3", 32'hC, 32'h33, 32'hC, 32'd3);
        im_data = 32'h44;
        step; st("f4", 32'h10, 32'h44, 32'h10, 32'd4);
        // memory wait states
        im_ready = 0; im_data = 32'hEE;
        for (int i = 0; i < 3; i++) begin
            step; st("wait", 32'h10, NOP, 32'h10, 32'd4);
            chk("wait_req", {31'b0, im_req}, 32'd1);
        end
        im_ready = 1; im_data = 32'h55;
        step; st("wait_done", 32'h14, 32'h55, 32'h14, 32'd5);
        // redirect to 0x40, then a redirect that squashes a ready fetch at 0x40
        id_cond = 1; id_npc = 32'h40; im_data = 32'h66;
        step; st("redir40", 32'h40, NOP, 32'h14, 32'd5);
        id_npc = 32'h200; im_data = 32'h99;
        step; st("squash", 32'h200, NOP, 32'h14, 32'd5);
        id_cond = 0; im_data = 32'h77;
        step; st("target", 32'h204, 32'h77, 32'h204, 32'd6);
        // stall then dc_wait with a pending redirect
        stall = 1; id_cond = 1; id_npc = 32'h300; im_data = 32'h88;
        #1 chk("stall_req", {31'b0, im_req}, 32'd0);
        step; st("stall1", 32'h204, 32'h77, 32'h204, 32'd6);
        stall = 0; dc_wait = 1;
        step; st("stall2", 32'h204, 32'h77, 32'h204, 32'd6);
        dc_wait = 0;
        step; st("unstall", 32'h300, NOP, 32'h204, 32'd6);
        id_cond = 0; im_data = 32'hAA;
        step; st("f300", 32'h304, 32'hAA, 32'h304, 32'd7);
        // illegal and trap together: illegal wins
        id_illegal_instr = 1; id_halt = 1; im_data = 32'hBB;
        step; st("illegal", 32'h304, NOP, 32'h304, 32'd7);
        chk("illegal_halted", {31'b0, if_halted}, 32'd1);
        chk("illegal_exc", {30'b0, if_exc_code}, 32'd1);
        chk("illegal_req", {31'b0, im_req}, 32'd0);
        id_illegal_instr = 0; id_halt = 0; id_cond = 1; id_npc = 32'h400;
        step; step; st("halt_abs", 32'h304, NOP, 32'h304, 32'd7);
        chk("halt_abs_exc", {30'b0, if_exc_code}, 32'd1);
        chk("halt_abs_halted", {31'b0, if_halted}, 32'd1);
        rst = 0; id_cond = 0;
        step; st("rst2", 32'h0, NOP, 32'h0, 32'd0);
        chk("rst2_halted", {31'b0, if_halted}, 32'd0);
        chk("rst2_exc", {30'b0, if_exc_code}, 32'd0);
        chk("rst2_req", {31'b0, im_req}, 32'd1);
        // misaligned redirect target
        rst = 1; id_cond = 1; id_npc = 32'h102; im_data = 32'hCC;
        step; st("misal", 32'h0, NOP, 32'h0, 32'd0);
        chk("misal_exc", {30'b0, if_exc_code}, 32'd2);
        chk("misal_halted", {31'b0, if_halted}, 32'd1);
        // plain trap reports cause 00
        rst = 0; id_cond = 0;
        step;
        rst = 1; id_halt = 1;
        step;
        chk("trap_halted", {31'b0, if_halted}, 32'd1);
        chk("trap_exc", {30'b0, if_exc_code}, 32'd0);
        chk("trap_cnt", if_fetch_cnt, 32'd0);
        // PC and counter wraparound
        rst = 0; id_halt = 0;
        step;
        rst = 1; id_cond = 1; id_npc = 32'hFFFF_FFFC;
        step; chk("wrap_adr0", im_adr, 32'hFFFF_FFFC);
        dut.cnt = 32'hFFFF_FFFF;
        id_cond = 0; im_data = 32'hCAFE;
        step; st("wrap", 32'h0, 32'hCAFE, 32'h0, 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
